// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, types and GF(2^8) helper.
// Imported by aes_sbox and aes_key_expand.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int NR    = 10;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  localparam byte_t RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box lookup, FIPS-197 table.
// Latency: combinational. Backpressure: none (pure function).
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t addr,
  output byte_t data
);

  // Row r holds entries 16*r .. 16*r+15, most significant byte first.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data = SBOX_TABLE[{addr, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key (0..10) per valid/ready handshake.
// Latency: start to first key 1 cycle, then one key per cycle with no bubbles.
// Backpressure: holds round_key/round_idx while rk_valid && !rk_ready. Option: AES_KEY_CACHE_EN.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic             done
`ifdef AES_KEY_CACHE_EN
  ,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
`endif
);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  byte_t            rcon_q, rcon_d;

  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w, t_w;
  word_t n0, n1, n2, n3;
  logic  hs;
  logic  last;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .addr (rot_w3[8*g +: 8]),
      .data (sub_w[8*g +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon_q, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign hs   = vld_q & rk_ready;
  assign last = (idx_q == 4'(NR));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          rcon_d  = RCON_INIT;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (hs) begin
          if (last) begin
            // Key and index stay visible after the final handshake.
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            key_d  = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rcon_q  <= rcon_d;
    end
  end

  assign rk_valid  = vld_q;
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef AES_KEY_CACHE_EN
  // Keeps every delivered key so decryption can walk them in reverse.
  logic [KEY_W-1:0] cache_q [NR+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) cache_q[i] <= '0;
    end else if (hs) begin
      cache_q[idx_q] <= key_q;
    end
  end

  assign rd_key = (rd_idx <= 4'(NR)) ? cache_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a GF(2^8)-based FIPS-197 reference model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
`ifdef AES_KEY_CACHE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_rk [11];

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
`ifdef AES_KEY_CACHE_EN
    ,
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    logic [7:0] b;
    logic [7:0] s;
    if (v == 8'h00) inv = 8'h00;
    else for (int k = 0; k < 254; k++) inv = gmul(inv, v);
    s = inv;
    b = inv;
    for (int k = 0; k < 4; k++) begin
      b = {b[6:0], b[7]};
      s = s ^ b;
    end
    return s ^ 8'h63;
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic do_start(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Drives rk_ready until all 11 keys are taken; returns at the done cycle.
  task automatic run_keys(input string tag, input bit rnd, input int stall_at,
                          input int inject_at, input logic [127:0] inject_key,
                          output int ncyc);
    int         exp_idx = 0;
    int         stall_left = 0;
    bit         stall_used = 1'b0;
    bit         injected = 1'b0;
    bit         was_stalled = 1'b0;
    logic [127:0] hold_key = '0;
    logic [3:0]   hold_idx = '0;
    ncyc = 0;
    while (exp_idx <= 10 && ncyc < 400) begin
      check({tag, "_vld_busy"}, {126'd0, rk_valid, busy}, 128'd3);
      if (was_stalled) begin
        check({tag, "_stall_key"}, round_key, hold_key);
        check({tag, "_stall_idx"}, {124'd0, round_idx}, {124'd0, hold_idx});
      end
      if (!stall_used && int'(round_idx) == stall_at) begin
        stall_left = 5;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      was_stalled = !rk_ready;
      hold_key = round_key;
      hold_idx = round_idx;
      if (!injected && int'(round_idx) == inject_at) begin
        key_in   = inject_key;
        start    = 1'b1;
        injected = 1'b1;
      end
      if (rk_valid && rk_ready) begin
        check({tag, "_idx"}, {124'd0, round_idx}, {124'd0, 4'(exp_idx)});
        check({tag, "_key"}, round_key, exp_rk[exp_idx]);
        exp_idx++;
      end
      tick();
      start = 1'b0;
      ncyc++;
    end
    if (exp_idx <= 10) check({tag, "_timeout"}, 128'(exp_idx), 128'd11);
    check({tag, "_done"}, {125'd0, done, rk_valid, busy}, 128'd4);
    check({tag, "_last_idx"}, {124'd0, round_idx}, 128'd10);
  endtask

  int ncyc;
  logic [127:0] rkey;
  logic [127:0] other;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    key_in = '0;
`ifdef AES_KEY_CACHE_EN
    rd_idx = 4'd0;
`endif
    #3;
    check("reset_key", round_key, 128'd0);
    check("reset_ctl", {123'd0, rk_valid, round_idx, busy, done}, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: FIPS-197 key, ready always high
    build_model(FIPS_KEY);
    do_start(FIPS_KEY);
    check("s1_first_key", round_key, FIPS_KEY);
    run_keys("s1", 1'b0, -1, -1, '0, ncyc);
    check("s1_latency", 128'(ncyc + 1), 128'd12);
    check("s1_rk10_const", round_key, FIPS_RK10);
    tick();
    check("s1_done_pulse", {127'd0, done}, 128'd0);
`ifdef AES_KEY_CACHE_EN
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      #1;
      check("cache_rd", rd_key, exp_rk[i]);
    end
    rd_idx = 4'd1;
    #1;
    check("cache_rk1_const", rd_key, FIPS_RK1);
    rd_idx = 4'd12;
    #1;
    check("cache_oob", rd_key, 128'd0);
    rd_idx = 4'd0;
`endif

    // 2: all-zero key, then a random key started in the done cycle
    build_model(128'd0);
    do_start(128'd0);
    run_keys("s2", 1'b0, -1, -1, '0, ncyc);
    check("s2_rk10_const", round_key, ZERO_RK10);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    build_model(rkey);
    key_in = rkey;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s2_restart", {125'd0, done, rk_valid, busy}, 128'd3);
    check("s2_restart_key", round_key, rkey);
    run_keys("s2r", 1'b1, -1, -1, '0, ncyc);
    tick();

    // 3: five-cycle stall at idx3, randomized ready elsewhere
    build_model(FIPS_KEY);
    do_start(FIPS_KEY);
    run_keys("s3", 1'b1, 3, -1, '0, ncyc);
    tick();

    // 4: start with another key at idx5 must be ignored
    other = {$urandom, $urandom, $urandom, $urandom};
    do_start(FIPS_KEY);
    run_keys("s4", 1'b1, -1, 5, other, ncyc);
    tick();
    check("s4_idle", {126'd0, rk_valid, busy}, 128'd0);

    // 5: reset at idx6, then a clean rerun
    do_start(FIPS_KEY);
    rk_ready = 1'b1;
    for (int n = 0; n < 40 && round_idx != 4'd6; n++) tick();
    check("s5_reached6", {124'd0, round_idx}, 128'd6);
    #2;
    rst = 1'b1;
    #1;
    check("s5_rst_key", round_key, 128'd0);
    check("s5_rst_ctl", {123'd0, rk_valid, round_idx, busy, done}, 128'd0);
`ifdef AES_KEY_CACHE_EN
    rd_idx = 4'd0;
    #1;
    check("s5_cache_clr", rd_key, 128'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("s5_idle_hold", {126'd0, rk_valid, busy}, 128'd0);
    do_start(FIPS_KEY);
    run_keys("s5", 1'b0, -1, -1, '0, ncyc);
    check("s5_latency", 128'(ncyc + 1), 128'd12);
    check("s5_rk10_const", round_key, FIPS_RK10);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
